// File: rtl/decode_stage_v2_if.sv
// Signal bundle around the decode stage: fetch side, register file reads,
// EX/MEM forwarding ports and the registered execute-side outputs.
interface decode_stage_v2_if #(
    parameter int DATA_W = 32
);
    logic              if_valid;
    logic [31:0]       if_id_reg;
    logic              stall;
    logic              flush;
    logic              hazard_stall;
    logic [2:0]        register_select_1;
    logic [2:0]        register_select_2;
    logic [DATA_W-1:0] selected_register_value_1;
    logic [DATA_W-1:0] selected_register_value_2;
    logic              fwd0_valid;
    logic [2:0]        fwd0_reg;
    logic [1:0]        fwd0_wb_en;
    logic [DATA_W-1:0] fwd0_value;
    logic              fwd1_valid;
    logic [2:0]        fwd1_reg;
    logic [1:0]        fwd1_wb_en;
    logic [DATA_W-1:0] fwd1_value;
    logic              id_valid;
    logic [2:0]        alu_opcode;
    logic [4:0]        memory_access_code;
    logic [2:0]        audio_opcode;
    logic [DATA_W-1:0] operand_value1;
    logic [DATA_W-1:0] operand_value2;
    logic [1:0]        register_writeback_enable;
    logic [2:0]        writeback_register_encoding;
    logic [1:0]        audio_channel_select;
    logic [31:0]       id_ex_instruction;

    // The surrounding pipeline drives fetch, regfile and forwarding inputs.
    modport master (
        output if_valid, if_id_reg, stall, flush,
        output selected_register_value_1, selected_register_value_2,
        output fwd0_valid, fwd0_reg, fwd0_wb_en, fwd0_value,
        output fwd1_valid, fwd1_reg, fwd1_wb_en, fwd1_value,
        input  hazard_stall, register_select_1, register_select_2,
        input  id_valid, alu_opcode, memory_access_code, audio_opcode,
        input  operand_value1, operand_value2,
        input  register_writeback_enable, writeback_register_encoding,
        input  audio_channel_select, id_ex_instruction
    );

    modport slave (
        input  if_valid, if_id_reg, stall, flush,
        input  selected_register_value_1, selected_register_value_2,
        input  fwd0_valid, fwd0_reg, fwd0_wb_en, fwd0_value,
        input  fwd1_valid, fwd1_reg, fwd1_wb_en, fwd1_value,
        output hazard_stall, register_select_1, register_select_2,
        output id_valid, alu_opcode, memory_access_code, audio_opcode,
        output operand_value1, operand_value2,
        output register_writeback_enable, writeback_register_encoding,
        output audio_channel_select, id_ex_instruction
    );
endinterface

// File: rtl/decode_stage_v2.sv
// Decode stage: field decode, half-word operand forwarding, immediate placement,
// load-use interlock and a valid-tagged ID/EX register with stall and flush.
module decode_stage_v2 #(
    parameter int DATA_W           = 32,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int FWD_ENABLE       = 1
) (
    input logic              clock,
    input logic              reset,
    decode_stage_v2_if.slave bus
);
    localparam int CNT_W = (LOAD_USE_BUBBLES > 1) ? $clog2(LOAD_USE_BUBBLES + 1) : 1;

    logic [31:0] instr;
    logic        imm_flag;
    logic [1:0]  instr_type;
    logic [2:0]  op;
    logic [1:0]  channel;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;

    assign instr      = bus.if_id_reg;
    assign imm_flag   = instr[31];
    assign instr_type = instr[30:29];
    assign op         = instr[28:26];
    assign channel    = instr[25:24];
    assign rs1        = instr[21:19];
    assign rs2        = instr[18:16];
    assign imm        = instr[15:0];

    assign bus.register_select_1 = rs1;
    assign bus.register_select_2 = rs2;

    logic is_alu_type;
    logic is_move;
    logic is_arith;
    logic is_mem;
    logic is_audio;
    logic rs1_used;
    logic rs2_used;

    assign is_alu_type = (instr_type == 2'b01);
    assign is_move     = is_alu_type && op[2] && (op[1] || op[0]);
    assign is_arith    = is_alu_type && !is_move;
    assign is_mem      = (instr_type == 2'b10);
    assign is_audio    = (instr_type == 2'b11);
    assign rs1_used    = (instr_type != 2'b00);
    assign rs2_used    = rs1_used && !imm_flag;

    // Each half picks EX, then MEM, then the regfile; bits above 31 follow the lower half.
    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [2:0]        src,
        input logic [DATA_W-1:0] rf,
        input logic              v0,
        input logic [2:0]        r0,
        input logic [1:0]        e0,
        input logic [DATA_W-1:0] d0,
        input logic              v1,
        input logic [2:0]        r1,
        input logic [1:0]        e1,
        input logic [DATA_W-1:0] d1
    );
        logic              hit0_lo;
        logic              hit0_hi;
        logic              hit1_lo;
        logic              hit1_hi;
        logic [DATA_W-1:0] lo_src;
        logic [DATA_W-1:0] hi_src;
        logic [DATA_W-1:0] result;
        hit0_lo = v0 && (r0 == src) && e0[0];
        hit0_hi = v0 && (r0 == src) && e0[1];
        hit1_lo = v1 && (r1 == src) && e1[0];
        hit1_hi = v1 && (r1 == src) && e1[1];
        lo_src  = hit0_lo ? d0 : (hit1_lo ? d1 : rf);
        hi_src  = hit0_hi ? d0 : (hit1_hi ? d1 : rf);
        result  = lo_src;
        result[31:16] = hi_src[31:16];
        return result;
    endfunction

    logic              fwd0_live;
    logic              fwd1_live;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] imm_ext;

    assign fwd0_live = bus.fwd0_valid && (FWD_ENABLE != 0);
    assign fwd1_live = bus.fwd1_valid && (FWD_ENABLE != 0);
    assign imm_ext   = {{(DATA_W-16){1'b0}}, imm};

    assign src1 = rs1_used ? fwd_mux(rs1, bus.selected_register_value_1,
                                     fwd0_live, bus.fwd0_reg, bus.fwd0_wb_en, bus.fwd0_value,
                                     fwd1_live, bus.fwd1_reg, bus.fwd1_wb_en, bus.fwd1_value)
                           : bus.selected_register_value_1;
    assign src2 = rs2_used ? fwd_mux(rs2, bus.selected_register_value_2,
                                     fwd0_live, bus.fwd0_reg, bus.fwd0_wb_en, bus.fwd0_value,
                                     fwd1_live, bus.fwd1_reg, bus.fwd1_wb_en, bus.fwd1_value)
                           : bus.selected_register_value_2;

    logic [DATA_W-1:0] dec_op1;
    logic [DATA_W-1:0] dec_op2;
    logic [1:0]        dec_wb_en;
    logic [2:0]        dec_alu;
    logic [4:0]        dec_mem;
    logic [2:0]        dec_audio;

    // Immediates overwrite the forwarded operand; unmatched flag=1 cases keep registers.
    always_comb begin
        dec_op1 = src1;
        dec_op2 = src2;
        if (imm_flag) begin
            if (is_arith || is_mem || (is_move && op == 3'b101)) begin
                dec_op2 = imm_ext;
            end else if (is_move && op == 3'b110) begin
                dec_op2 = imm_ext << 16;
            end else if (is_audio && op == 3'b100) begin
                dec_op1 = imm_ext << 16;
            end else if (is_audio && op == 3'b110) begin
                dec_op1 = imm_ext << 8;
            end
        end
    end

    always_comb begin
        dec_wb_en = 2'b00;
        if (is_arith) begin
            dec_wb_en = 2'b11;
        end else if ((is_move && op == 3'b101) || (is_mem && op == 3'b001)) begin
            dec_wb_en = 2'b01;
        end else if ((is_move && op == 3'b110) || (is_mem && op == 3'b010)) begin
            dec_wb_en = 2'b10;
        end
    end

    assign dec_alu   = is_arith ? op : 3'b000;
    assign dec_mem   = is_mem ? {op[2], op[1], op[1], op[0], op[0]} : 5'b00000;
    assign dec_audio = is_audio ? op : 3'b000;

    logic              id_valid_q;
    logic [2:0]        alu_q;
    logic [4:0]        mem_q;
    logic [2:0]        audio_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [1:0]        wb_en_q;
    logic [2:0]        wb_reg_q;
    logic [1:0]        channel_q;
    logic [31:0]       held_instr;
    logic [CNT_W-1:0]  bubble_cnt;

    // A held half-word load whose rd is read by the incoming instruction must bubble.
    logic             held_is_load;
    logic [2:0]       held_rd;
    logic             uses_held_rd;
    logic             load_use;
    logic             hazard;
    logic [CNT_W-1:0] cnt_next;

    assign held_is_load = (held_instr[30:29] == 2'b10) &&
                          ((held_instr[28:26] == 3'b001) || (held_instr[28:26] == 3'b010));
    assign held_rd      = held_instr[21:19];
    assign uses_held_rd = (rs1_used && rs1 == held_rd) || (rs2_used && rs2 == held_rd);
    assign load_use     = (LOAD_USE_BUBBLES != 0) && id_valid_q && held_is_load &&
                          bus.if_valid && uses_held_rd;
    assign hazard       = (bubble_cnt != '0) || load_use;
    assign cnt_next     = (bubble_cnt != '0) ? bubble_cnt - 1'b1
                                             : CNT_W'(LOAD_USE_BUBBLES - 1);

    assign bus.hazard_stall = hazard;

    always_ff @(posedge clock) begin
        if (reset) begin
            id_valid_q <= 1'b0;
            alu_q      <= '0;
            mem_q      <= '0;
            audio_q    <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            wb_en_q    <= '0;
            wb_reg_q   <= '0;
            channel_q  <= '0;
            held_instr <= '0;
            bubble_cnt <= '0;
        end else if (!bus.stall) begin
            if (bus.flush) begin
                bubble_cnt <= '0;
            end else if (hazard) begin
                bubble_cnt <= cnt_next;
            end
            if (bus.flush || hazard || !bus.if_valid) begin
                id_valid_q <= 1'b0;
                alu_q      <= '0;
                mem_q      <= '0;
                audio_q    <= '0;
                op1_q      <= '0;
                op2_q      <= '0;
                wb_en_q    <= '0;
                wb_reg_q   <= '0;
                channel_q  <= '0;
                held_instr <= '0;
            end else begin
                id_valid_q <= 1'b1;
                alu_q      <= dec_alu;
                mem_q      <= dec_mem;
                audio_q    <= dec_audio;
                op1_q      <= dec_op1;
                op2_q      <= dec_op2;
                wb_en_q    <= dec_wb_en;
                wb_reg_q   <= rs1;
                channel_q  <= channel;
                held_instr <= instr;
            end
        end
    end

    assign bus.id_valid                    = id_valid_q;
    assign bus.alu_opcode                  = alu_q;
    assign bus.memory_access_code          = mem_q;
    assign bus.audio_opcode                = audio_q;
    assign bus.operand_value1              = op1_q;
    assign bus.operand_value2              = op2_q;
    assign bus.register_writeback_enable   = wb_en_q;
    assign bus.writeback_register_encoding = wb_reg_q;
    assign bus.audio_channel_select        = channel_q;
    assign bus.id_ex_instruction           = held_instr;
endmodule

// File: tb/tb_decode_stage_v2.sv
// Directed scenarios followed by a randomized run, all checked against a
// behavioural decode/interlock model built from the instruction-set rules.
module tb_decode_stage_v2;
    localparam int DW  = 40;
    localparam int LUB = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    decode_stage_v2_if #(.DATA_W(DW)) bus ();

    decode_stage_v2 #(
        .DATA_W(DW),
        .LOAD_USE_BUBBLES(LUB),
        .FWD_ENABLE(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic          valid;
        logic [2:0]    alu;
        logic [4:0]    mac;
        logic [2:0]    aud;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [1:0]    wben;
        logic [2:0]    wbreg;
        logic [1:0]    ch;
        logic [31:0]   instr;
    } exp_t;

    exp_t exp_out = '0;
    int   pending = 0;
    int   errors  = 0;
    int   checks  = 0;
    bit   last_hz = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // 0 = EX port, 1 = MEM port, 2 = register file
    function automatic int src_of(logic [2:0] r, int half);
        if (bus.fwd0_valid && bus.fwd0_reg == r && bus.fwd0_wb_en[half]) return 0;
        if (bus.fwd1_valid && bus.fwd1_reg == r && bus.fwd1_wb_en[half]) return 1;
        return 2;
    endfunction

    function automatic logic [DW-1:0] value_of(int s, logic [DW-1:0] rf);
        if (s == 0) return bus.fwd0_value;
        if (s == 1) return bus.fwd1_value;
        return rf;
    endfunction

    function automatic logic [DW-1:0] operand(logic [2:0] r, logic [DW-1:0] rf);
        logic [DW-1:0] vl;
        logic [DW-1:0] vh;
        vl = value_of(src_of(r, 0), rf);
        vh = value_of(src_of(r, 1), rf);
        return {vl[DW-1:32], vh[31:16], vl[15:0]};
    endfunction

    function automatic exp_t decode_model(logic [31:0] ins);
        exp_t          e;
        int            kind;
        int            op;
        bit            immf;
        bit            move;
        bit            arith;
        logic [DW-1:0] imm;
        e     = '0;
        kind  = int'(ins[30:29]);
        op    = int'(ins[28:26]);
        immf  = ins[31];
        imm   = DW'(ins[15:0]);
        move  = (kind == 1) && (op >= 5);
        arith = (kind == 1) && (op < 5);
        e.valid = 1'b1;
        e.instr = ins;
        e.wbreg = ins[21:19];
        e.ch    = ins[25:24];
        if (arith) e.alu = 3'(op);
        if (kind == 2) e.mac = 5'((op / 4) * 16 + ((op / 2) % 2) * 12 + (op % 2) * 3);
        if (kind == 3) e.aud = 3'(op);
        e.op1 = (kind != 0) ? operand(ins[21:19], bus.selected_register_value_1) : bus.selected_register_value_1;
        e.op2 = (kind != 0 && !immf) ? operand(ins[18:16], bus.selected_register_value_2) : bus.selected_register_value_2;
        if (immf) begin
            if (arith || kind == 2 || (move && op == 5)) e.op2 = imm;
            else if (move && op == 6) e.op2 = imm * 65536;
            else if (kind == 3 && op == 4) e.op1 = imm * 65536;
            else if (kind == 3 && op == 6) e.op1 = imm * 256;
        end
        if (arith) e.wben = 2'd3;
        else if ((move && op == 5) || (kind == 2 && op == 1)) e.wben = 2'd1;
        else if ((move && op == 6) || (kind == 2 && op == 2)) e.wben = 2'd2;
        return e;
    endfunction

    function automatic bit model_hazard();
        logic [31:0] held;
        logic [31:0] inc;
        logic [2:0]  rd;
        int          hop;
        if (pending > 0) return 1'b1;
        if (LUB == 0 || !exp_out.valid || !bus.if_valid) return 1'b0;
        held = exp_out.instr;
        inc  = bus.if_id_reg;
        hop  = int'(held[28:26]);
        if (held[30:29] != 2'b10 || (hop != 1 && hop != 2)) return 1'b0;
        rd = held[21:19];
        if (inc[30:29] == 2'b00) return 1'b0;
        return (inc[21:19] == rd) || (!inc[31] && inc[18:16] == rd);
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic applyStimulus();
        bit hz;
        @(negedge clock);
        hz = model_hazard();
        checkOutput("hazard_stall", 64'(bus.hazard_stall), 64'(hz));
        checkOutput("register_select_1", 64'(bus.register_select_1), 64'(bus.if_id_reg[21:19]));
        checkOutput("register_select_2", 64'(bus.register_select_2), 64'(bus.if_id_reg[18:16]));
        last_hz = hz;
        if (reset) begin
            exp_out = '0;
            pending = 0;
        end else if (bus.stall) begin
            pending = pending;
        end else if (bus.flush) begin
            exp_out = '0;
            pending = 0;
        end else if (hz) begin
            exp_out = '0;
            pending = (pending > 0) ? pending - 1 : LUB - 1;
        end else if (bus.if_valid) begin
            exp_out = decode_model(bus.if_id_reg);
        end else begin
            exp_out = '0;
        end
        @(posedge clock);
        #1;
        checkOutput("id_valid", 64'(bus.id_valid), 64'(exp_out.valid));
        checkOutput("alu_opcode", 64'(bus.alu_opcode), 64'(exp_out.alu));
        checkOutput("memory_access_code", 64'(bus.memory_access_code), 64'(exp_out.mac));
        checkOutput("audio_opcode", 64'(bus.audio_opcode), 64'(exp_out.aud));
        checkOutput("operand_value1", 64'(bus.operand_value1), 64'(exp_out.op1));
        checkOutput("operand_value2", 64'(bus.operand_value2), 64'(exp_out.op2));
        checkOutput("wb_enable", 64'(bus.register_writeback_enable), 64'(exp_out.wben));
        checkOutput("wb_register", 64'(bus.writeback_register_encoding), 64'(exp_out.wbreg));
        checkOutput("channel_select", 64'(bus.audio_channel_select), 64'(exp_out.ch));
        checkOutput("id_ex_instruction", 64'(bus.id_ex_instruction), 64'(exp_out.instr));
    endtask

    task automatic idleInputs();
        bus.if_valid = 1'b0;
        bus.if_id_reg = '0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.selected_register_value_1 = '0;
        bus.selected_register_value_2 = '0;
        bus.fwd0_valid = 1'b0;
        bus.fwd0_reg = '0;
        bus.fwd0_wb_en = '0;
        bus.fwd0_value = '0;
        bus.fwd1_valid = 1'b0;
        bus.fwd1_reg = '0;
        bus.fwd1_wb_en = '0;
        bus.fwd1_value = '0;
    endtask

    logic [31:0] load_lo;
    logic [31:0] add_r2;
    logic [31:0] add_r4;
    logic [31:0] ins;

    initial begin
        idleInputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus();
        reset = 1'b0;

        $display("[TB] arithmetic immediate");
        bus.if_valid = 1'b1;
        bus.if_id_reg = {1'b1, 2'b01, 3'b010, 2'b00, 2'b00, 3'd3, 3'd0, 16'h1234};
        bus.selected_register_value_1 = DW'(32'h10);
        applyStimulus();
        checkOutput("arith_op1", 64'(bus.operand_value1), 64'h10);
        checkOutput("arith_op2", 64'(bus.operand_value2), 64'h1234);
        checkOutput("arith_alu", 64'(bus.alu_opcode), 64'd2);
        checkOutput("arith_wb", 64'(bus.register_writeback_enable), 64'd3);

        $display("[TB] load-use interlock");
        load_lo = {1'b0, 2'b10, 3'b001, 2'b00, 2'b00, 3'd2, 3'd0, 16'h0040};
        add_r2  = {1'b0, 2'b01, 3'b000, 2'b00, 2'b00, 3'd1, 3'd2, 16'h0000};
        bus.if_id_reg = load_lo;
        applyStimulus();
        checkOutput("load_mac", 64'(bus.memory_access_code), 64'b00011);
        bus.if_id_reg = add_r2;
        applyStimulus();
        checkOutput("lu_hazard_seen", 64'(last_hz), 64'd1);
        checkOutput("lu_bubble_valid", 64'(bus.id_valid), 64'd0);
        checkOutput("lu_hazard_clear", 64'(bus.hazard_stall), 64'd0);
        applyStimulus();
        checkOutput("lu_add_issued", 64'(bus.id_ex_instruction), 64'(add_r2));

        $display("[TB] half-word forwarding");
        add_r4 = {1'b0, 2'b01, 3'b000, 2'b00, 2'b00, 3'd4, 3'd0, 16'h0000};
        bus.if_id_reg = add_r4;
        bus.selected_register_value_1 = '0;
        bus.fwd0_valid = 1'b1;
        bus.fwd0_reg = 3'd4;
        bus.fwd0_wb_en = 2'b01;
        bus.fwd0_value = DW'(32'hAAAA5555);
        bus.fwd1_valid = 1'b1;
        bus.fwd1_reg = 3'd4;
        bus.fwd1_wb_en = 2'b11;
        bus.fwd1_value = DW'(32'h12345678);
        applyStimulus();
        checkOutput("fwd_op1", 64'(bus.operand_value1), 64'h12345555);

        $display("[TB] stall and flush");
        bus.stall = 1'b1;
        bus.if_id_reg = {1'b0, 2'b11, 3'b011, 2'b01, 2'b00, 3'd5, 3'd6, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("stall_hold_instr", 64'(bus.id_ex_instruction), 64'(add_r4));
        end
        bus.flush = 1'b1;
        applyStimulus();
        checkOutput("stall_beats_flush", 64'(bus.id_valid), 64'd1);
        bus.stall = 1'b0;
        applyStimulus();
        checkOutput("flush_bubble", 64'(bus.id_valid), 64'd0);
        bus.flush = 1'b0;

        $display("[TB] audio period immediate");
        bus.fwd0_valid = 1'b0;
        bus.fwd1_valid = 1'b0;
        bus.if_id_reg = {1'b1, 2'b11, 3'b110, 2'b10, 2'b00, 3'd1, 3'd2, 16'hBEEF};
        applyStimulus();
        checkOutput("audio_op1", 64'(bus.operand_value1), 64'h00BEEF00);
        checkOutput("audio_opcode_val", 64'(bus.audio_opcode), 64'd6);
        checkOutput("audio_channel", 64'(bus.audio_channel_select), 64'd2);
        checkOutput("audio_wb", 64'(bus.register_writeback_enable), 64'd0);

        $display("[TB] reset mid-hazard");
        bus.if_id_reg = load_lo;
        applyStimulus();
        bus.if_id_reg = add_r2;
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_valid", 64'(bus.id_valid), 64'd0);
        checkOutput("reset_hazard", 64'(bus.hazard_stall), 64'd0);
        reset = 1'b0;

        $display("[TB] randomized run");
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            bus.stall = ($urandom_range(0, 7) == 0);
            bus.flush = ($urandom_range(0, 11) == 0);
            if (!last_hz) begin
                ins = $urandom;
                ins[21:19] = 3'($urandom_range(1, 3));
                ins[18:16] = 3'($urandom_range(1, 3));
                bus.if_id_reg = ins;
                bus.if_valid = ($urandom_range(0, 7) != 0);
            end
            bus.selected_register_value_1 = DW'({$urandom, $urandom});
            bus.selected_register_value_2 = DW'({$urandom, $urandom});
            bus.fwd0_valid = 1'($urandom_range(0, 1));
            bus.fwd0_reg = 3'($urandom_range(1, 3));
            bus.fwd0_wb_en = 2'($urandom_range(0, 3));
            bus.fwd0_value = DW'({$urandom, $urandom});
            bus.fwd1_valid = 1'($urandom_range(0, 1));
            bus.fwd1_reg = 3'($urandom_range(1, 3));
            bus.fwd1_wb_en = 2'($urandom_range(0, 3));
            bus.fwd1_value = DW'({$urandom, $urandom});
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
